// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA text-mode types, screen geometry and pipeline latency.
//   rgb444_t      - 12-bit RGB444 colour
//   SCREEN_W/H    - visible resolution in pixels
//   TEXT_COLS/ROWS - text grid size in cells
//   PIPE_LATENCY  - clocks from sync-generator inputs to pixel outputs
//   mul_const     - constant multiply built only from shifts and adds
package vga_pkg;
   typedef logic [11:0] rgb444_t;
   localparam int unsigned SCREEN_W     = 640;
   localparam int unsigned SCREEN_H     = 480;
   localparam int unsigned TEXT_COLS    = 160;
   localparam int unsigned TEXT_ROWS    = 60;
   localparam int unsigned PIPE_LATENCY = 5;
   function automatic logic [31:0] mul_const(input logic [31:0] a, input int unsigned k);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++) acc = k[i] ? acc + (a << i) : acc;
      return acc;
   endfunction
endpackage

// File: rtl/sync_delay.sv
// sync_delay: DEPTH-stage shift register with a configurable reset value.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   d_i           - WIDTH-bit input
//   q_o           - d_i delayed by DEPTH clocks (RST_VAL while refilling)
module sync_delay
   import vga_pkg::*;
#(
   parameter int unsigned       DEPTH   = 1,
   parameter int unsigned       WIDTH   = 1,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] pipe_q [DEPTH];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end
   assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/text_pixel_gen.sv
// text_pixel_gen: 5-clock text-mode pixel pipeline (text buffer -> font ROM -> RGB).
//   clk_i, rst_ni                 - clock, asynchronous active-low reset
//   pixel_x_i, pixel_y_i          - current pixel from the sync generator
//   video_on_i, hsync_i, vsync_i  - raw timing (syncs active-low)
//   text_addr_o / text_data_i     - text buffer port, 1-clk read latency
//   font_addr_o / font_data_i     - font ROM port, 1-clk read latency
//   cursor_col_i/row_i/en_i       - cursor cell and enable
//   fg_color_i, bg_color_i        - RGB444 colours
//   rgb_o, hsync_o, vsync_o, video_on_o - registered outputs, all aligned
module text_pixel_gen
   import vga_pkg::*;
#(
   parameter int unsigned FONT_ADDR_WIDTH = 10,
   parameter int unsigned FONT_DATA_WIDTH = 4,
   parameter int unsigned GLYPH_ROWS_LOG2 = 3,
   parameter int unsigned TEXT_COLS       = 160,
   parameter int unsigned TEXT_ADDR_WIDTH = 14,
   parameter int unsigned BLINK_FRAMES    = 30
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [9:0]                 pixel_x_i,
   input  logic [9:0]                 pixel_y_i,
   input  logic                       video_on_i,
   input  logic                       hsync_i,
   input  logic                       vsync_i,
   output logic [TEXT_ADDR_WIDTH-1:0] text_addr_o,
   input  logic [7:0]                 text_data_i,
   output logic [FONT_ADDR_WIDTH-1:0] font_addr_o,
   input  logic [FONT_DATA_WIDTH-1:0] font_data_i,
   input  logic [7:0]                 cursor_col_i,
   input  logic [5:0]                 cursor_row_i,
   input  logic                       cursor_en_i,
   input  logic [11:0]                fg_color_i,
   input  logic [11:0]                bg_color_i,
   output logic [11:0]                rgb_o,
   output logic                       hsync_o,
   output logic                       vsync_o,
   output logic                       video_on_o
);
   localparam int unsigned XS  = $clog2(FONT_DATA_WIDTH);
   localparam int unsigned CW  = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned S4W = 3 + XS + 24;
   // video_on low, both syncs high (inactive) while the pipeline refills
   localparam logic [S4W-1:0] S4_RST = {3'b011, {(XS + 24){1'b0}}};

   logic [TEXT_ADDR_WIDTH-1:0] text_addr_q, text_addr_d;
   logic [FONT_ADDR_WIDTH-1:0] font_addr_q, font_addr_d;
   logic                       inv3_q, inv3_d, inv4_q;
   logic [11:0]                rgb_q, rgb_d;
   logic                       hsync_q, vsync_q, video_on_q;
   logic                       vsync_prev_q, blink_q, blink_d;
   logic [CW-1:0]              frame_q, frame_d;
   logic [9:0]                 cell_col, cell_row;
   logic                       cursor_hit, hit_s2, vs_fall, frame_wrap, pix;
   logic [GLYPH_ROWS_LOG2-1:0] glyph_row_s2;
   logic [S4W-1:0]             s4_d, s4_q;
   logic                       vo_s4, hs_s4, vs_s4;
   logic [XS-1:0]              xg_s4;
   rgb444_t                    fg_s4, bg_s4;
   logic [FONT_DATA_WIDTH-1:0] glyph_shift;

   assign cell_col = pixel_x_i >> XS;
   assign cell_row = pixel_y_i >> GLYPH_ROWS_LOG2;
   assign s4_d     = {video_on_i, hsync_i, vsync_i, pixel_x_i[XS-1:0], fg_color_i, bg_color_i};
   assign {vo_s4, hs_s4, vs_s4, xg_s4, fg_s4, bg_s4} = s4_q;

   sync_delay #(.DEPTH(2), .WIDTH(GLYPH_ROWS_LOG2), .RST_VAL('0)) u_row (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(pixel_y_i[GLYPH_ROWS_LOG2-1:0]), .q_o(glyph_row_s2));
   sync_delay #(.DEPTH(2), .WIDTH(1), .RST_VAL(1'b0)) u_hit (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(cursor_hit), .q_o(hit_s2));
   sync_delay #(.DEPTH(4), .WIDTH(S4W), .RST_VAL(S4_RST)) u_s4 (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(s4_d), .q_o(s4_q));

   always_comb begin
      text_addr_d = TEXT_ADDR_WIDTH'(mul_const(32'(cell_row), TEXT_COLS) + 32'(cell_col));
      // blink_q is sampled here so a blink toggle never rewrites pixels already in flight
      cursor_hit  = cursor_en_i & blink_q & (cell_col == 10'(cursor_col_i)) & (cell_row == 10'(cursor_row_i));
      font_addr_d = FONT_ADDR_WIDTH'({text_data_i[6:0], glyph_row_s2});
      inv3_d      = text_data_i[7] ^ hit_s2;
      // shift the addressed pixel into the MSB (MSB is the leftmost pixel)
      glyph_shift = font_data_i << xg_s4;
      pix         = glyph_shift[FONT_DATA_WIDTH-1];
      rgb_d       = vo_s4 ? ((pix ^ inv4_q) ? fg_s4 : bg_s4) : 12'h000;
      vs_fall     = vsync_prev_q & ~vsync_i;
      frame_wrap  = frame_q == CW'(BLINK_FRAMES - 1);
      frame_d     = vs_fall ? (frame_wrap ? '0 : frame_q + CW'(1)) : frame_q;
      blink_d     = blink_q ^ (vs_fall & frame_wrap);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         text_addr_q  <= '0;
         font_addr_q  <= '0;
         inv3_q       <= 1'b0;
         inv4_q       <= 1'b0;
         rgb_q        <= '0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         video_on_q   <= 1'b0;
         vsync_prev_q <= 1'b0;
         frame_q      <= '0;
         blink_q      <= 1'b1;
      end else begin
         text_addr_q  <= text_addr_d;
         font_addr_q  <= font_addr_d;
         inv3_q       <= inv3_d;
         inv4_q       <= inv3_q;
         rgb_q        <= rgb_d;
         hsync_q      <= hs_s4;
         vsync_q      <= vs_s4;
         video_on_q   <= vo_s4;
         vsync_prev_q <= vsync_i;
         frame_q      <= frame_d;
         blink_q      <= blink_d;
      end
   end

   assign text_addr_o = text_addr_q;
   assign font_addr_o = font_addr_q;
   assign rgb_o       = rgb_q;
   assign hsync_o     = hsync_q;
   assign vsync_o     = vsync_q;
   assign video_on_o  = video_on_q;
endmodule

// File: tb/tb_text_pixel_gen.sv
// tb_text_pixel_gen: directed plus random checks of text_pixel_gen against a cell/glyph reference model.
module tb_text_pixel_gen;
   logic        clk = 1'b0, rst_n;
   logic [9:0]  x, y;
   logic        vo, hs, vs, cen;
   logic [7:0]  ccol;
   logic [5:0]  crow;
   logic [11:0] fg, bg;
   logic [13:0] taddr;
   logic [7:0]  tdata;
   logic [9:0]  faddr;
   logic [3:0]  fdata;
   logic [11:0] rgb;
   logic        hs_o, vs_o, vo_o;

   logic [7:0]  tbuf [16384];
   logic [3:0]  font [1024];

   typedef struct packed {
      logic [13:0] ta;
      logic [9:0]  fa;
      logic [11:0] rgb;
      logic        hs, vs, vo;
   } exp_t;
   exp_t ring [8];

   int   errors = 0, checks = 0, cnum = 0, edges = 0;
   logic prev_vs = 1'b0;

   text_pixel_gen dut (
      .clk_i(clk), .rst_ni(rst_n), .pixel_x_i(x), .pixel_y_i(y),
      .video_on_i(vo), .hsync_i(hs), .vsync_i(vs),
      .text_addr_o(taddr), .text_data_i(tdata), .font_addr_o(faddr), .font_data_i(fdata),
      .cursor_col_i(ccol), .cursor_row_i(crow), .cursor_en_i(cen),
      .fg_color_i(fg), .bg_color_i(bg),
      .rgb_o(rgb), .hsync_o(hs_o), .vsync_o(vs_o), .video_on_o(vo_o));

   always #5 clk = ~clk;

   // synchronous-read memories feeding the DUT
   always @(posedge clk) begin
      tdata <= tbuf[taddr];
      fdata <= font[faddr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rgb"}, 32'(rgb), 0);
      chk({tag, "_hsync"}, 32'(hs_o), 1);
      chk({tag, "_vsync"}, 32'(vs_o), 1);
      chk({tag, "_video_on"}, 32'(vo_o), 0);
      chk({tag, "_text_addr"}, 32'(taddr), 0);
      chk({tag, "_font_addr"}, 32'(faddr), 0);
   endtask

   task automatic reset_model();
      edges = 0;
      prev_vs = 1'b0;
      cnum = 0;
      foreach (ring[i]) ring[i] = '{ta: '0, fa: '0, rgb: '0, hs: 1'b1, vs: 1'b1, vo: 1'b0};
   endtask

   // One clock: predict this cycle's results from the cell/glyph rules, then check what
   // the DUT shows now against the predictions for 1, 3 and 5 cycles ago.
   task automatic cyc();
      exp_t e;
      int col, row, addr;
      logic [7:0] ch;
      logic [3:0] g;
      logic hit, pix;
      col  = int'(x) / 4;
      row  = int'(y) / 8;
      addr = (row * 160 + col) % 16384;
      ch   = tbuf[addr];
      e.ta = 14'(addr);
      e.fa = {ch[6:0], y[2:0]};
      g    = font[e.fa];
      pix  = g[3 - int'(x) % 4];
      hit  = cen && ((edges / 30) % 2 == 0) && col == int'(ccol) && row == int'(crow);
      e.rgb = !vo ? 12'h000 : ((pix ^ ch[7] ^ hit) ? fg : bg);
      e.hs = hs;
      e.vs = vs;
      e.vo = vo;
      if (prev_vs && !vs) edges++;
      prev_vs = vs;
      ring[cnum & 7] = e;
      @(negedge clk);
      chk("text_addr", 32'(taddr), 32'(ring[(cnum - 1) & 7].ta));
      chk("font_addr", 32'(faddr), 32'(ring[(cnum - 3) & 7].fa));
      chk("rgb", 32'(rgb), 32'(ring[(cnum - 5) & 7].rgb));
      chk("hsync", 32'(hs_o), 32'(ring[(cnum - 5) & 7].hs));
      chk("vsync", 32'(vs_o), 32'(ring[(cnum - 5) & 7].vs));
      chk("video_on", 32'(vo_o), 32'(ring[(cnum - 5) & 7].vo));
      cnum++;
      @(posedge clk);
      #1;
   endtask

   task automatic toggle30();
      repeat (30) begin
         vs = 1'b0;
         cyc();
         vs = 1'b1;
         cyc();
      end
   endtask

   task automatic rand_cycles(input int n);
      repeat (n) begin
         if ($urandom_range(1) == 1) begin
            x = 10'($urandom_range(15));
            y = 10'($urandom_range(31));
         end else begin
            x = 10'($urandom);
            y = 10'($urandom);
         end
         vo   = $urandom_range(3) != 0;
         hs   = $urandom_range(7) != 0;
         vs   = ($urandom_range(7) == 0) ? ~vs : vs;
         cen  = 1'($urandom);
         ccol = 8'($urandom_range(3));
         crow = 6'($urandom_range(3));
         fg   = 12'($urandom);
         bg   = 12'($urandom);
         cyc();
      end
   endtask

   initial begin
      logic [11:0] exp4 [4];
      int lows, first;
      exp4 = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
      rst_n = 1'b1;
      x = '0; y = '0; vo = 1'b0; hs = 1'b1; vs = 1'b1;
      cen = 1'b0; ccol = '0; crow = '0; fg = '0; bg = '0;
      foreach (tbuf[i]) tbuf[i] = 8'($urandom);
      foreach (font[i]) font[i] = 4'($urandom);
      tbuf[0]          = 8'h00;
      tbuf[320]        = 8'h41;
      tbuf[321]        = 8'h41;
      tbuf[323]        = 8'hC1;
      font[10'h209]    = 4'b1010;

      #2 rst_n = 1'b0;
      #1 chk_reset("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      reset_model();

      x = 10'd5; y = 10'd17; vo = 1'b1; fg = 12'hFFF; bg = 12'h000;
      cyc();
      chk("text_addr_321", 32'(taddr), 321);
      cyc();
      cyc();
      chk("font_addr_209", 32'(faddr), 32'h209);

      for (int i = 0; i < 4; i++) begin
         x = 10'(i);
         cyc();
      end
      cyc();
      for (int k = 0; k < 4; k++) begin
         chk("glyph_1010", 32'(rgb), 32'(exp4[k]));
         cyc();
      end

      vo = 1'b0;
      hs = 1'b0;
      lows = 0;
      first = -1;
      for (int k = 0; k < 108; k++) begin
         if (k == 96) hs = 1'b1;
         cyc();
         if (hs_o === 1'b0) begin
            lows++;
            if (first < 0) first = k;
         end
      end
      chk("hsync_low_len", 32'(lows), 96);
      chk("hsync_delay", 32'(first), 4);
      chk("blank_rgb", 32'(rgb), 0);

      vo = 1'b1; cen = 1'b1; ccol = 8'd1; crow = 6'd2; x = 10'd4; y = 10'd17;
      repeat (6) cyc();
      chk("cursor_on", 32'(rgb), 32'h000);
      toggle30();
      repeat (6) cyc();
      chk("cursor_off", 32'(rgb), 32'hFFF);
      toggle30();
      ccol = 8'd3; x = 10'd12;
      repeat (6) cyc();
      chk("attr_cursor_on", 32'(rgb), 32'hFFF);
      toggle30();
      repeat (6) cyc();
      chk("attr_cursor_off", 32'(rgb), 32'h000);

      rand_cycles(2000);

      vo = 1'b1; hs = 1'b1; fg = 12'hFFF; bg = 12'hFFF;
      repeat (6) cyc();
      chk("pre_reset_rgb", 32'(rgb), 32'hFFF);
      #3 rst_n = 1'b0;
      #1 chk_reset("async_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      reset_model();
      rand_cycles(300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
